// File: rtl/tick_recovery_pkg.sv
// Shared constants for the divided game clocks: divisors, default stall timeouts, counter width.
// Used by both the clock divider and the receiving tick_recovery block.
package tick_recovery_pkg;

  localparam int CNT_W = 28;

  localparam int DIV_BLINK = 50000000;
  localparam int DIV_GAME  = 1000000;
  localparam int DIV_FAST  = 100000;

  // Roughly twice the nominal period of each divided clock
  localparam logic [CNT_W-1:0] TIMEOUT_BLINK_DEF = 28'd200000000;
  localparam logic [CNT_W-1:0] TIMEOUT_GAME_DEF  = 28'd4000000;
  localparam logic [CNT_W-1:0] TIMEOUT_FAST_DEF  = 28'd400000;

  // The warm-up must cover the synchronizer depth plus the edge-history flop
  function automatic logic [2:0] warm_init(input int sync_stages);
    return 3'(sync_stages + 1);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divided-clock channel: synchronizer, rising-edge strobe and stall watchdog.
// Latency: tick at edge N+SYNC_STAGES+1 after the input is first sampled at edge N; no backpressure.
module tick_channel
  import tick_recovery_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = TIMEOUT_FAST_DEF
) (
  input  logic clock_in,
  input  logic rst,
  input  logic warm,
  input  logic async_in,
  output logic tick,
  output logic stall
);

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - 1'b1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   hist;
  logic                   rise_q;
  logic [CNT_W-1:0]       cnt;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clock_in) begin
    if (rst) begin
      sync   <= '0;
      hist   <= 1'b0;
      rise_q <= 1'b0;
      tick   <= 1'b0;
      cnt    <= '0;
      stall  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], async_in};
      hist   <= sync_out;
      rise_q <= sync_out & ~hist & ~warm;
      tick   <= rise_q & ~warm;

      // rise_q is the value tick takes on this edge, so a coincident timeout loses to the tick
      if (warm) begin
        cnt <= '0;
      end else if (rise_q) begin
        cnt   <= '0;
        stall <= 1'b0;
      end else if (cnt != TIMEOUT) begin
        cnt <= cnt + 1'b1;
        if (cnt == TIMEOUT_M1) stall <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_recovery.sv
// Re-times the divided game clocks into clock_in enables, plus frame counter, blink phase and stall flags.
// Latency: ticks SYNC_STAGES+1 cycles after input sampling, counters one cycle after the tick; no backpressure.
module tick_recovery
  import tick_recovery_pkg::*;
#(
  parameter int               SYNC_STAGES   = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_BLINK = TIMEOUT_BLINK_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT_GAME  = TIMEOUT_GAME_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT_FAST  = TIMEOUT_FAST_DEF,
  parameter int               FRAME_W       = 16
) (
  input  logic               clock_in,
  input  logic               rst,
  input  logic               clk_blink,
  input  logic               clk_game,
  input  logic               clk_fast,
  input  logic               clear_frame,
  output logic               tick_blink,
  output logic               tick_game,
  output logic               tick_fast,
  output logic               blink_phase,
  output logic [FRAME_W-1:0] frame_count,
  output logic               stall_blink,
  output logic               stall_game,
  output logic               stall_fast
);

  logic [2:0] warm_cnt;
  logic       warm;

  assign warm = (warm_cnt != 3'd0);

  always_ff @(posedge clock_in) begin
    if (rst) begin
      warm_cnt <= warm_init(SYNC_STAGES);
    end else if (warm) begin
      warm_cnt <= warm_cnt - 3'd1;
    end
  end

  tick_channel #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT_BLINK)) u_blink (
    .clock_in (clock_in),
    .rst      (rst),
    .warm     (warm),
    .async_in (clk_blink),
    .tick     (tick_blink),
    .stall    (stall_blink)
  );

  tick_channel #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT_GAME)) u_game (
    .clock_in (clock_in),
    .rst      (rst),
    .warm     (warm),
    .async_in (clk_game),
    .tick     (tick_game),
    .stall    (stall_game)
  );

  tick_channel #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT_FAST)) u_fast (
    .clock_in (clock_in),
    .rst      (rst),
    .warm     (warm),
    .async_in (clk_fast),
    .tick     (tick_fast),
    .stall    (stall_fast)
  );

  // A clear coinciding with a game tick drops that tick from the count
  always_ff @(posedge clock_in) begin
    if (rst) begin
      blink_phase <= 1'b0;
      frame_count <= '0;
    end else begin
      blink_phase <= blink_phase ^ tick_blink;
      if (clear_frame) begin
        frame_count <= '0;
      end else if (tick_game) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_recovery.sv
// Directed bench for tick_recovery with shortened timeouts and an 8-bit frame counter.
module tb_tick_recovery;

  localparam int FW = 8;

  logic          clock_in = 1'b0;
  logic          rst = 1'b1;
  logic          clk_blink = 1'b0, clk_game = 1'b0, clk_fast = 1'b0;
  logic          clear_frame = 1'b0;
  logic          tick_blink, tick_game, tick_fast, blink_phase;
  logic [FW-1:0] frame_count;
  logic          stall_blink, stall_game, stall_fast;

  int n_cmp = 0;
  int n_err = 0;
  int n_fast = 0;
  int n_game = 0;

  tick_recovery #(
    .SYNC_STAGES   (2),
    .TIMEOUT_BLINK (28'd50),
    .TIMEOUT_GAME  (28'd20),
    .TIMEOUT_FAST  (28'd8),
    .FRAME_W       (FW)
  ) dut (
    .clock_in    (clock_in),
    .rst         (rst),
    .clk_blink   (clk_blink),
    .clk_game    (clk_game),
    .clk_fast    (clk_fast),
    .clear_frame (clear_frame),
    .tick_blink  (tick_blink),
    .tick_game   (tick_game),
    .tick_fast   (tick_fast),
    .blink_phase (blink_phase),
    .frame_count (frame_count),
    .stall_blink (stall_blink),
    .stall_game  (stall_game),
    .stall_fast  (stall_fast)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) begin
    if (tick_fast === 1'b1) n_fast <= n_fast + 1;
    if (tick_game === 1'b1) n_game <= n_game + 1;
  end

  function automatic logic [31:0] outs();
    return {17'd0, tick_blink, tick_game, tick_fast, blink_phase,
            stall_blink, stall_game, stall_fast, frame_count};
  endfunction

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic v);
    case (ch)
      0:       clk_blink = v;
      1:       clk_game  = v;
      default: clk_fast  = v;
    endcase
  endtask

  // Two cycles high, two low; returns just after the edge that raises the tick
  task automatic pulse(input int ch);
    set_ch(ch, 1'b1);
    steps(2);
    set_ch(ch, 1'b0);
    steps(2);
  endtask

  initial begin
    int n0;

    // 1. reset with clk_game already high, then warm-up
    clk_game = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outs", outs(), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("warmup_outs", outs(), 32'd0);
    end
    check("warmup_no_game_tick", 32'(n_game), 32'd0);
    clk_game = 1'b0;
    steps(2);
    clk_game = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("game_tick_early", 32'(tick_game), 32'd0);
    end
    step();
    check("game_first_tick", 32'(tick_game), 32'd1);
    step();
    check("game_tick_one_cycle", 32'(tick_game), 32'd0);
    check("frame_after_first", 32'(frame_count), 32'd1);
    clk_game = 1'b0;

    // 2. latency and 6-cycle toggling on clk_fast
    check("fast_stalled_idle", 32'(stall_fast), 32'd1);
    clk_fast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fast_tick_early", 32'(tick_fast), 32'd0);
    end
    step();
    check("fast_tick_n3", 32'(tick_fast), 32'd1);
    check("fast_stall_clr", 32'(stall_fast), 32'd0);
    step();
    check("fast_tick_one_cycle", 32'(tick_fast), 32'd0);
    clk_fast = 1'b0;
    steps(3);
    n0 = n_fast;
    for (int p = 0; p < 5; p++) begin
      clk_fast = 1'b1;
      steps(3);
      clk_fast = 1'b0;
      steps(3);
    end
    steps(6);
    check("fast_tick_count", 32'(n_fast - n0), 32'd5);

    // 4. stall set at count 8, cleared by a tick, and a tick exactly at count 8
    pulse(2);
    check("stall_pulse_tick", 32'(tick_fast), 32'd1);
    steps(7);
    check("stall_count7", 32'(stall_fast), 32'd0);
    step();
    check("stall_count8", 32'(stall_fast), 32'd1);
    steps(3);
    check("stall_sticky", 32'(stall_fast), 32'd1);
    pulse(2);
    check("stall_clr_tick", 32'(tick_fast), 32'd1);
    check("stall_clr", 32'(stall_fast), 32'd0);
    steps(4);
    pulse(2);
    check("tick_at_8", 32'(tick_fast), 32'd1);
    check("tick_at_8_stall", 32'(stall_fast), 32'd0);
    step();
    check("tick_at_8_after", 32'(stall_fast), 32'd0);

    // 3. frame wrap and clear priority
    for (int i = 0; i < 254; i++) pulse(1);
    step();
    check("frame_max", 32'(frame_count), 32'hFF);
    pulse(1);
    step();
    check("frame_wrap", 32'(frame_count), 32'h00);
    for (int i = 0; i < 5; i++) pulse(1);
    step();
    check("frame_five", 32'(frame_count), 32'd5);
    pulse(1);
    check("clear_with_tick", 32'(tick_game), 32'd1);
    clear_frame = 1'b1;
    step();
    clear_frame = 1'b0;
    check("frame_cleared", 32'(frame_count), 32'd0);

    // 5. blink phase and simultaneous ticks
    pulse(0);
    step();
    check("blink_phase_1", 32'(blink_phase), 32'd1);
    pulse(0);
    step();
    check("blink_phase_2", 32'(blink_phase), 32'd0);
    pulse(0);
    step();
    check("blink_phase_3", 32'(blink_phase), 32'd1);
    clk_blink = 1'b1; clk_game = 1'b1; clk_fast = 1'b1;
    steps(2);
    clk_blink = 1'b0; clk_game = 1'b0; clk_fast = 1'b0;
    steps(2);
    check("simul_ticks", 32'({tick_blink, tick_game, tick_fast}), 32'b111);
    step();
    check("simul_frame", 32'(frame_count), 32'd1);
    check("simul_phase", 32'(blink_phase), 32'd0);

    // 6. mid-operation reset
    for (int i = 0; i < 41; i++) pulse(1);
    steps(22);
    check("pre_rst_frame", 32'(frame_count), 32'd42);
    check("pre_rst_stall_game", 32'(stall_game), 32'd1);
    rst = 1'b1;
    clk_blink = 1'b1; clk_game = 1'b1; clk_fast = 1'b1;
    step();
    check("mid_rst_outs", outs(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_rst_warmup", outs(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
